switch_cfg_loader: RTL
======================

Name: switch_cfg_loader

Overview:
- Configuration controller for the 9x9 programmable switch box (5 top/bottom wires, 4 left/right wires).
- Accepts a framed configuration stream over a valid/ready byte interface and validates every routing entry plus a checksum.
- Commits all 18 entries atomically to the switch box's 6-bit select registers, so the switch never sees a partially loaded routing.
- Sits between the configuration port (bitstream source) and the switch-matrix select inputs.

Parameters:
- NTB, 5, wires per top/bottom side.
- NLR, 4, wires per left/right side.
- EW, 6, entry width: [2:0] source side, [5:3] source index.
- HDR, 8'hA5, frame header byte.
- NENT (localparam), 2*NTB+2*NLR = 18, entry count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  input byte valid.
- cfg_ready  out  1  loader can accept a byte.
- cfg_data  in  8  input byte.
- cfg_abort  in  1  discard the frame in progress.
- cfg_busy  out  1  frame in progress (state != IDLE).
- cfg_out  out  NENT*EW  active configuration; entry k at [6k+5:6k]. k=0..4 top0..4, 5..9 bottom0..4, 10..13 left0..3, 14..17 right0..3.
- cfg_update  out  1  one-cycle pulse when cfg_out changes.
- cfg_done  out  1  one-cycle pulse on successful commit.
- cfg_err  out  1  one-cycle pulse on rejected frame.
- err_code  out  2  01 checksum, 10 invalid entry, 11 abort; holds until the next cfg_err.
- cfg_loaded  out  1  sticky: set after the first successful commit.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; cfg_out all zero (every switch output high-Z); shadow, counter and checksum cleared.
  - cfg_update, cfg_done, cfg_err, err_code and cfg_loaded all 0.
- Handshake:
  - A transfer occurs on an edge with cfg_valid & cfg_ready.
  - cfg_ready is decoded from state: 1 in IDLE, LOAD and CSUM; 0 in CHECK.
  - cfg_valid gaps are tolerated anywhere in a frame; there is no timeout.
- States:
  - IDLE: a transferred byte equal to HDR moves to LOAD and clears cnt, csum and the error flags. Any other byte is dropped silently, with no error.
  - LOAD: each transfer writes shadow[cnt]=cfg_data[5:0] and does csum^=cfg_data. At cnt==NENT-1 go to CSUM, otherwise cnt+1.
  - CSUM: one transfer; set csum_bad if cfg_data != csum; go to CHECK.
  - CHECK (single cycle, no transfer):
    - No error: on the exiting edge, cfg_out<=shadow, cfg_update=cfg_done=1 for one cycle, cfg_loaded<=1.
    - Error: cfg_err=1 for one cycle and err_code set; cfg_out unchanged.
    - Always return to IDLE.
- Entry validation (per LOAD byte; a sticky inv flag is set if any check fails):
  - cfg_data[7:6] != 0.
  - Side code 5..7. Side 0 (off) is always valid, index ignored.
  - Side 1 (top) or 3 (bottom) with index >= NTB; side 2 (right) or 4 (left) with index >= NLR.
  - Self-loop: source side/index equals the entry's own destination (e.g. k=1 top1 sourced from side 1 index 1).
- Error priority: invalid entry (10) over checksum (01).
- Abort:
  - cfg_abort=1 in LOAD, CSUM or CHECK: on that edge go to IDLE, pulse cfg_err with err_code=11 next cycle, shadow discarded, cfg_out unchanged.
  - Abort wins over a simultaneous transfer; the byte is dropped.
  - Abort in IDLE is ignored.
- Throughput: a new HDR is accepted in the cycle after CHECK. Minimum frame is 20 transfers + 1 CHECK cycle.
- Reset mid-frame: immediate return to reset values, including cfg_out=0. There is no partial commit in any case.

Test Plan:
- Reset, then HDR, 18x 0x00, csum 0x00 -> cfg_done and cfg_update pulse once, cfg_out=0, cfg_loaded=1, cfg_busy low after CHECK.
- HDR, entry0=0x14 (top0 from left2), 17x 0x00, csum 0x14 -> cfg_out[5:0]=0x14, all other bits 0; cfg_update one cycle after the csum transfer.
- Same frame with csum 0x15 -> cfg_err, err_code=01, cfg_out holds its previous value, cfg_update stays 0.
- Entries 0x2A (right5) at k=0, and separately 0x09 (self-loop) at k=1, and 0x05 (side 5) at k=2, each with a correct csum -> cfg_err, err_code=10 each time. 0x2A with a wrong csum also gives 10.
- cfg_abort asserted during the 7th entry transfer -> byte dropped, cfg_err with err_code=11, state IDLE, cfg_out unchanged; an immediately following valid frame commits normally.
- Valid frame sent with random cfg_valid gaps, and rst_n pulsed low mid-frame -> cfg_out=0 at once, cfg_loaded=0; bytes before a fresh HDR are ignored.

Source files
------------

// File: rtl/switch_cfg_loader.sv
// Configuration loader for the 9x9 switch box: receives a framed, checksummed
// byte stream, validates all routing entries and commits them atomically.
module switch_cfg_loader #(
  parameter  int          NTB  = 5,
  parameter  int          NLR  = 4,
  parameter  int          EW   = 6,
  parameter  logic [7:0]  HDR  = 8'hA5,
  localparam int          NENT = 2*NTB + 2*NLR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [7:0]           cfg_data,
  input  logic                 cfg_abort,
  output logic                 cfg_busy,
  output logic [NENT*EW-1:0]   cfg_out,
  output logic                 cfg_update,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [1:0]           err_code,
  output logic                 cfg_loaded
);

  localparam int CW = $clog2(NENT);

  localparam logic [2:0] SIDE_OFF   = 3'd0;
  localparam logic [2:0] SIDE_TOP   = 3'd1;
  localparam logic [2:0] SIDE_RIGHT = 3'd2;
  localparam logic [2:0] SIDE_BOT   = 3'd3;
  localparam logic [2:0] SIDE_LEFT  = 3'd4;

  localparam logic [2:0]    NTB3     = 3'(NTB);
  localparam logic [2:0]    NLR3     = 3'(NLR);
  localparam logic [CW-1:0] K_BOT    = CW'(NTB);
  localparam logic [CW-1:0] K_LEFT   = CW'(2*NTB);
  localparam logic [CW-1:0] K_RIGHT  = CW'(2*NTB + NLR);
  localparam logic [CW-1:0] K_LAST   = CW'(NENT - 1);

  localparam logic [1:0] ERR_CSUM  = 2'b01;
  localparam logic [1:0] ERR_INV   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CSUM, ST_CHECK} state_t;

  state_t                     r_state, w_next;
  logic [CW-1:0]              r_cnt;
  logic [7:0]                 r_csum;
  logic                       r_inv;
  logic                       r_csum_bad;
  logic [NENT-1:0][EW-1:0]    r_shadow;
  logic [NENT*EW-1:0]         r_cfg_out;
  logic                       r_update;
  logic                       r_done;
  logic                       r_err;
  logic [1:0]                 r_err_code;
  logic                       r_loaded;
  logic                       w_xfer;
  logic                       w_entry_bad;

  // An entry is bad if reserved bits are set, the source is out of range, or
  // it routes a destination wire back onto itself.
  function automatic logic entry_bad(input logic [7:0] d, input logic [CW-1:0] k);
    logic [2:0] side, idx, own_side, own_idx;
    logic       bad;
    side = d[2:0];
    idx  = d[5:3];
    if (k < K_BOT) begin
      own_side = SIDE_TOP;   own_idx = 3'(k);
    end else if (k < K_LEFT) begin
      own_side = SIDE_BOT;   own_idx = 3'(k - K_BOT);
    end else if (k < K_RIGHT) begin
      own_side = SIDE_LEFT;  own_idx = 3'(k - K_LEFT);
    end else begin
      own_side = SIDE_RIGHT; own_idx = 3'(k - K_RIGHT);
    end
    bad = (d[7:6] != 2'b00);
    case (side)
      SIDE_OFF:              ;
      SIDE_TOP, SIDE_BOT:    if (idx >= NTB3) bad = 1'b1;
      SIDE_RIGHT, SIDE_LEFT: if (idx >= NLR3) bad = 1'b1;
      default:               bad = 1'b1;
    endcase
    if (side != SIDE_OFF && side == own_side && idx == own_idx) bad = 1'b1;
    return bad;
  endfunction

  assign w_xfer      = cfg_valid & cfg_ready;
  assign w_entry_bad = entry_bad(cfg_data, r_cnt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_xfer && cfg_data == HDR) w_next = ST_LOAD;
      ST_LOAD: begin
        if (cfg_abort)                    w_next = ST_IDLE;
        else if (w_xfer && r_cnt == K_LAST) w_next = ST_CSUM;
      end
      ST_CSUM: begin
        if (cfg_abort)   w_next = ST_IDLE;
        else if (w_xfer) w_next = ST_CHECK;
      end
      ST_CHECK: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b1;
    cfg_busy  = 1'b1;
    case (r_state)
      ST_IDLE:  cfg_busy  = 1'b0;
      ST_CHECK: cfg_ready = 1'b0;
      default:  ;
    endcase
  end

  // NOTE: the shadow array is reset along with everything else; a reset must
  // leave no stale routing that a later commit could expose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_csum     <= '0;
      r_inv      <= 1'b0;
      r_csum_bad <= 1'b0;
      r_shadow   <= '0;
      r_cfg_out  <= '0;
      r_update   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_loaded   <= 1'b0;
    end else begin
      r_update <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer && cfg_data == HDR) begin
            r_cnt      <= '0;
            r_csum     <= '0;
            r_inv      <= 1'b0;
            r_csum_bad <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (cfg_abort) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_ABORT;
          end else if (w_xfer) begin
            r_shadow[r_cnt] <= cfg_data[EW-1:0];
            r_csum          <= r_csum ^ cfg_data;
            if (w_entry_bad)     r_inv <= 1'b1;
            if (r_cnt != K_LAST) r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_CSUM: begin
          if (cfg_abort) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_ABORT;
          end else if (w_xfer) begin
            r_csum_bad <= (cfg_data != r_csum);
          end
        end
        ST_CHECK: begin
          if (cfg_abort) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_ABORT;
          end else if (r_inv) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_INV;
          end else if (r_csum_bad) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_CSUM;
          end else begin
            r_cfg_out <= r_shadow;
            r_update  <= 1'b1;
            r_done    <= 1'b1;
            r_loaded  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_out    = r_cfg_out;
  assign cfg_update = r_update;
  assign cfg_done   = r_done;
  assign cfg_err    = r_err;
  assign err_code   = r_err_code;
  assign cfg_loaded = r_loaded;

endmodule
